// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types and sizing helpers for the forwarding scoreboard.
// Contents: slot_t (one in-flight destination entry), FWD_RF select value,
//           addr_w()/fwd_w() width helpers used for parameter derivation.
package fwd_pkg;

  // Upper bound on register address width carried in a slot (up to 256 regs).
  localparam int MAX_ADDR_W = 8;

  // Forward select value meaning "read the register file".
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic                  vld;
    logic [MAX_ADDR_W-1:0] rd;
    logic                  is_load;
  } slot_t;

  function automatic int addr_w(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  function automatic int fwd_w(input int wb_age);
    return (wb_age > 0) ? $clog2(wb_age + 1) : 1;
  endfunction

endpackage

// File: rtl/fwd_scoreboard_lookup.sv
// sb_lookup: combinational youngest-match search over the scoreboard slots.
// Ports: i_slots (age 0 = youngest), i_addr/i_use (source operand),
//        o_hit, o_age (age of youngest matching slot), o_is_load.
module sb_lookup
  import fwd_pkg::*;
#(
  parameter int WB_AGE = 2,
  parameter int ADDR_W = 5,
  parameter int AGE_W  = 2
) (
  input  slot_t [WB_AGE-1:0] i_slots,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic               i_use,
  output logic               o_hit,
  output logic [AGE_W-1:0]   o_age,
  output logic               o_is_load
);

  logic [MAX_ADDR_W-1:0] w_key;
  logic                  w_active;

  assign w_key    = MAX_ADDR_W'(i_addr);
  // x0 is hardwired zero: never matched even if a slot somehow held it.
  assign w_active = i_use && (i_addr != '0);

  // Scan oldest to youngest so the youngest match is the last to assign.
  always_comb begin
    o_hit     = 1'b0;
    o_age     = '0;
    o_is_load = 1'b0;
    for (int k = WB_AGE - 1; k >= 0; k--) begin
      if (w_active && i_slots[k].vld && (i_slots[k].rd == w_key)) begin
        o_hit     = 1'b1;
        o_age     = AGE_W'(k);
        o_is_load = i_slots[k].is_load;
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: RAW hazard / forwarding scoreboard beside the ID stage.
// Ports: i_id_vld, i_rs*_addr/_use, i_rd_addr/_wren, i_is_load, i_flush in;
//        o_stall (combinational), o_fwd_rs1/2 (registered, used by EX next cycle),
//        o_stall_cnt/o_fwd_cnt (perf counters, live only with SCOREBOARD_PERF_EN).
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int WB_AGE   = 2,
  parameter int LOAD_AGE = 2,
  parameter int ADDR_W   = addr_w(NUM_REGS),  // derived
  parameter int FWD_W    = fwd_w(WB_AGE)      // derived
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_id_vld,
  input  logic [ADDR_W-1:0] i_rs1_addr,
  input  logic [ADDR_W-1:0] i_rs2_addr,
  input  logic              i_rs1_use,
  input  logic              i_rs2_use,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_rd_wren,
  input  logic              i_is_load,
  input  logic              i_flush,
  output logic              o_stall,
  output logic [FWD_W-1:0]  o_fwd_rs1,
  output logic [FWD_W-1:0]  o_fwd_rs2,
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_fwd_cnt
);

  slot_t [WB_AGE-1:0] r_slots;
  logic [FWD_W-1:0]   r_fwd_rs1;
  logic [FWD_W-1:0]   r_fwd_rs2;

  logic               w_hit1, w_hit2;
  logic               w_ld1, w_ld2;
  logic [FWD_W-1:0]   w_age1, w_age2;
  logic               w_haz1, w_haz2;
  logic [FWD_W-1:0]   w_sel1, w_sel2;
  logic               w_issue;
  logic               w_alloc;
  slot_t              w_new_slot;

  sb_lookup #(.WB_AGE(WB_AGE), .ADDR_W(ADDR_W), .AGE_W(FWD_W)) u_lookup_rs1 (
    .i_slots  (r_slots),
    .i_addr   (i_rs1_addr),
    .i_use    (i_rs1_use),
    .o_hit    (w_hit1),
    .o_age    (w_age1),
    .o_is_load(w_ld1)
  );

  sb_lookup #(.WB_AGE(WB_AGE), .ADDR_W(ADDR_W), .AGE_W(FWD_W)) u_lookup_rs2 (
    .i_slots  (r_slots),
    .i_addr   (i_rs2_addr),
    .i_use    (i_rs2_use),
    .o_hit    (w_hit2),
    .o_age    (w_age2),
    .o_is_load(w_ld2)
  );

  // A producer at age k today sits at age k+1 when the consumer reaches EX;
  // a load is only forwardable once that age reaches LOAD_AGE.
  assign w_haz1 = w_hit1 && w_ld1 && ((int'(w_age1) + 1) < LOAD_AGE);
  assign w_haz2 = w_hit2 && w_ld2 && ((int'(w_age2) + 1) < LOAD_AGE);

  assign w_sel1 = w_hit1 ? (w_age1 + FWD_W'(1)) : FWD_W'(FWD_RF);
  assign w_sel2 = w_hit2 ? (w_age2 + FWD_W'(1)) : FWD_W'(FWD_RF);

  // Flush overrides both stall and issue.
  assign o_stall = i_id_vld && !i_flush && (w_haz1 || w_haz2);
  assign w_issue = i_id_vld && !i_flush && !o_stall;
  assign w_alloc = w_issue && i_rd_wren && (i_rd_addr != '0);

  always_comb begin
    w_new_slot         = '0;
    w_new_slot.vld     = 1'b1;
    w_new_slot.rd      = MAX_ADDR_W'(i_rd_addr);
    w_new_slot.is_load = i_is_load;
  end

  // Slots age unconditionally, so stalls release without a handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_slots <= '0;
    end else begin
      r_slots[0] <= w_alloc ? w_new_slot : '0;
      for (int k = 1; k < WB_AGE; k++) begin
        r_slots[k] <= r_slots[k-1];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fwd_rs1 <= '0;
      r_fwd_rs2 <= '0;
    end else begin
      r_fwd_rs1 <= w_issue ? w_sel1 : FWD_W'(FWD_RF);
      r_fwd_rs2 <= w_issue ? w_sel2 : FWD_W'(FWD_RF);
    end
  end

  assign o_fwd_rs1 = r_fwd_rs1;
  assign o_fwd_rs2 = r_fwd_rs2;

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_fwd_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (o_stall) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_issue && ((w_sel1 != '0) || (w_sel2 != '0))) begin
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_fwd_cnt   = r_fwd_cnt;
`else
  assign o_stall_cnt = 32'd0;
  assign o_fwd_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed vectors for fwd_scoreboard at defaults
// (WB_AGE=2, LOAD_AGE=2) plus a WB_AGE=3/LOAD_AGE=3 instance for long load-use.
// Each row: ID inputs, expected o_stall this cycle, expected selects next cycle.
module tb_fwd_scoreboard;

  typedef struct packed {
    logic       vld;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       fl;
  } in_t;

  typedef struct {
    in_t in;
    int  stall;
    int  f1;
    int  f2;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  in_t         in1 = '0;
  in_t         in2 = '0;

  logic        stall1, stall2;
  logic [1:0]  fwd1_rs1, fwd1_rs2, fwd2_rs1, fwd2_rs2;
  logic [31:0] scnt1, fcnt1, scnt2, fcnt2;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  fwd_scoreboard dut (
    .i_clk(clk), .i_rst(rst), .i_id_vld(in1.vld),
    .i_rs1_addr(in1.rs1), .i_rs2_addr(in1.rs2),
    .i_rs1_use(in1.u1), .i_rs2_use(in1.u2),
    .i_rd_addr(in1.rd), .i_rd_wren(in1.wr), .i_is_load(in1.ld), .i_flush(in1.fl),
    .o_stall(stall1), .o_fwd_rs1(fwd1_rs1), .o_fwd_rs2(fwd1_rs2),
    .o_stall_cnt(scnt1), .o_fwd_cnt(fcnt1)
  );

  fwd_scoreboard #(.WB_AGE(3), .LOAD_AGE(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_id_vld(in2.vld),
    .i_rs1_addr(in2.rs1), .i_rs2_addr(in2.rs2),
    .i_rs1_use(in2.u1), .i_rs2_use(in2.u2),
    .i_rd_addr(in2.rd), .i_rd_wren(in2.wr), .i_is_load(in2.ld), .i_flush(in2.fl),
    .o_stall(stall2), .o_fwd_rs1(fwd2_rs1), .o_fwd_rs2(fwd2_rs2),
    .o_stall_cnt(scnt2), .o_fwd_cnt(fcnt2)
  );

  function automatic in_t mk(input bit vld, input int rs1, input bit u1,
                             input int rs2, input bit u2, input int rd,
                             input bit wr, input bit ld, input bit fl);
    in_t x;
    x.vld = vld; x.rs1 = 5'(rs1); x.u1 = u1; x.rs2 = 5'(rs2); x.u2 = u2;
    x.rd = 5'(rd); x.wr = wr; x.ld = ld; x.fl = fl;
    return x;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic add_row(input in_t x, input int s, input int f1, input int f2);
    vec_t v;
    v.in = x; v.stall = s; v.f1 = f1; v.f2 = f2;
    vq.push_back(v);
  endtask

  // One ID cycle on the default DUT: stall mid-cycle, selects after the edge.
  task automatic step(input in_t x, input int es, input int e1, input int e2,
                      input string nm);
    in1 = x;
    @(negedge clk);
    check({nm, ".stall"}, int'(stall1), es);
    @(posedge clk);
    #1;
    check({nm, ".fwd_rs1"}, int'(fwd1_rs1), e1);
    check({nm, ".fwd_rs2"}, int'(fwd1_rs2), e2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    in_t bub, lw7, use7;
    bub  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    lw7  = mk(1, 1, 1, 0, 0, 7, 1, 1, 0);
    use7 = mk(1, 7, 1, 7, 1, 8, 1, 0, 0);

    // Back-to-back ALU: fwd 1 next, then 2 one cycle later.
    add_row(mk(1, 1, 1, 2, 1, 5, 1, 0, 0), 0, 0, 0);
    add_row(mk(1, 5, 1, 3, 1, 6, 1, 0, 0), 0, 1, 0);
    add_row(mk(1, 5, 1, 0, 1, 10, 1, 0, 0), 0, 2, 0);
    add_row(bub, 0, 0, 0); add_row(bub, 0, 0, 0);
    // Load-use: one stall cycle, then both operands from age 2.
    add_row(lw7, 0, 0, 0);
    add_row(use7, 1, 0, 0);
    add_row(use7, 0, 2, 2);
    add_row(bub, 0, 0, 0); add_row(bub, 0, 0, 0);
    // Double writer of x9: youngest wins.
    add_row(mk(1, 0, 1, 0, 0, 9, 1, 0, 0), 0, 0, 0);
    add_row(mk(1, 1, 1, 0, 0, 9, 1, 0, 0), 0, 0, 0);
    add_row(mk(1, 9, 1, 9, 1, 11, 1, 0, 0), 0, 1, 1);
    add_row(bub, 0, 0, 0); add_row(bub, 0, 0, 0);
    // x0 load then x0 reads; unused rs2 matching an in-flight load.
    add_row(mk(1, 1, 1, 0, 0, 0, 1, 1, 0), 0, 0, 0);
    add_row(mk(1, 0, 1, 0, 1, 12, 1, 0, 0), 0, 0, 0);
    add_row(mk(1, 1, 1, 0, 0, 13, 1, 1, 0), 0, 0, 0);
    add_row(mk(1, 1, 1, 13, 0, 14, 1, 0, 0), 0, 0, 0);
    add_row(bub, 0, 0, 0); add_row(bub, 0, 0, 0);
    // Flush on a dependent instruction: no stall, no allocation of x8.
    add_row(lw7, 0, 0, 0);
    add_row(mk(1, 7, 1, 7, 1, 8, 1, 0, 1), 0, 0, 0);
    add_row(mk(1, 8, 1, 7, 1, 15, 1, 0, 0), 0, 0, 2);
    // Invalid ID slot never stalls and produces zero selects.
    add_row(mk(1, 1, 1, 0, 0, 20, 1, 1, 0), 0, 0, 0);
    add_row(mk(0, 20, 1, 0, 0, 21, 1, 0, 0), 0, 0, 0);
    add_row(mk(1, 20, 1, 0, 0, 21, 1, 0, 0), 0, 2, 0);
    add_row(bub, 0, 0, 0); add_row(bub, 0, 0, 0);

    // Reset state.
    #2;
    check("reset.stall", int'(stall1), 0);
    check("reset.fwd_rs1", int'(fwd1_rs1), 0);
    check("reset.fwd_rs2", int'(fwd1_rs2), 0);
    check("reset.stall_cnt", int'(scnt1), 0);
    check("reset.fwd_cnt", int'(fcnt1), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].in, vq[i].stall, vq[i].f1, vq[i].f2, $sformatf("row%0d", i));
    end

    // Reset asserted mid-stall.
    step(lw7, 0, 0, 0, "rst.lw");
    in1 = use7;
    @(negedge clk);
    check("rst.pre_stall", int'(stall1), 1);
    rst = 1'b1;
    #1;
    check("rst.stall", int'(stall1), 0);
    check("rst.fwd_rs1", int'(fwd1_rs1), 0);
    check("rst.fwd_rs2", int'(fwd1_rs2), 0);
    check("rst.stall_cnt", int'(scnt1), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(use7, 0, 0, 0, "rst.post_issue");
    step(bub, 0, 0, 0, "rst.drain0");
    step(bub, 0, 0, 0, "rst.drain1");

    // Three load-use pairs for the performance counters.
    for (int p = 0; p < 3; p++) begin
      step(lw7, 0, 0, 0, $sformatf("pair%0d.lw", p));
      step(use7, 1, 0, 0, $sformatf("pair%0d.stall", p));
      step(use7, 0, 2, 2, $sformatf("pair%0d.issue", p));
      step(bub, 0, 0, 0, $sformatf("pair%0d.drain", p));
    end
`ifdef SCOREBOARD_PERF_EN
    check("perf.stall_cnt", int'(scnt1), 3);
    check("perf.fwd_cnt", int'(fcnt1), 3);
`else
    check("perf.stall_cnt_off", int'(scnt1), 0);
    check("perf.fwd_cnt_off", int'(fcnt1), 0);
`endif

    // WB_AGE=3, LOAD_AGE=3: load-use stalls two cycles, then select 3.
    in1 = bub;
    in2 = lw7;
    @(negedge clk); check("age3.lw.stall", int'(stall2), 0);
    @(posedge clk); #1;
    in2 = use7;
    @(negedge clk); check("age3.stall_c1", int'(stall2), 1);
    @(posedge clk); #1;
    check("age3.fwd_c1", int'(fwd2_rs1), 0);
    @(negedge clk); check("age3.stall_c2", int'(stall2), 1);
    @(posedge clk); #1;
    check("age3.fwd_c2", int'(fwd2_rs2), 0);
    @(negedge clk); check("age3.release", int'(stall2), 0);
    @(posedge clk); #1;
    check("age3.fwd_rs1", int'(fwd2_rs1), 3);
    check("age3.fwd_rs2", int'(fwd2_rs2), 3);
    in2 = bub;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised hazard/forwarding scoreboard for the in-order RISC-V pipeline. It replaces fixed per-stage address compares with a shift-register scoreboard of in-flight destination registers, generalised over register count and pipeline depth (EX→WB distance, load data latency). The block sits beside the ID stage. It takes the decoded instruction being issued, asserts a stall on unresolvable RAW hazards, and drives registered forwarding selects that the EX stage uses one cycle later.

## Interface
- NUM_REGS, 32: architectural registers; ADDR_W = $clog2(NUM_REGS).
- WB_AGE, 2: ages from EX entry (age 0) to WB (age WB_AGE); 2 = EX/MEM/WB.
- LOAD_AGE, 2: first age at which load data is forwardable; 1 ≤ LOAD_AGE ≤ WB_AGE.
- FWD_W, $clog2(WB_AGE+1): width of forwarding selects (derived, do not override).
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_id_vld  in  1  valid instruction in ID this cycle.
- i_rs1_addr, i_rs2_addr  in  ADDR_W each  source register addresses.
- i_rs1_use, i_rs2_use  in  1 each  instruction actually reads rs1/rs2.
- i_rd_addr  in  ADDR_W  destination address.
- i_rd_wren  in  1  instruction writes rd.
- i_is_load  in  1  instruction is a load.
- i_flush  in  1  branch taken in EX: ID instruction is killed.
- o_stall  out  1  hold PC and IF/ID; insert bubble into EX.
- o_fwd_rs1, o_fwd_rs2  out  FWD_W each  select for the operand in EX: 0 = register file, k = result held at age k.
- o_stall_cnt, o_fwd_cnt  out  32 each  performance counters (only with SCOREBOARD_PERF_EN).

## Operation
- Scoreboard is WB_AGE slots, age 0..WB_AGE-1. Each slot holds {vld, rd, is_load}.
- Every cycle all slots shift one age; the age WB_AGE-1 slot falls off.
- Register file is write-before-read, so an age WB_AGE producer needs no forwarding.
- Slot 0 loads {1, i_rd_addr, i_is_load} when i_id_vld & i_rd_wren & i_rd_addr≠0 & ~o_stall & ~i_flush. Otherwise it loads a bubble.
- Lookup per source (when *_use and addr≠0): find the youngest (smallest age k) valid slot with rd == addr.
  - Hit on a load with k+1 < LOAD_AGE → hazard.
  - Hit otherwise → next-cycle select = k+1.
  - No hit → select 0.
- o_stall = i_id_vld & ~i_flush & (hazard_rs1 | hazard_rs2). Combinational.
- o_fwd_rs* registered: take the lookup result when issuing; forced to 0 on stall, flush, or ~i_id_vld.
- Multiple in-flight writers of one register: the youngest wins.
- x0 is never allocated and never matched.
- rs1 == rs2 resolves identically on both selects.

## Timing
- Reset (async, i_rst=1): all slots invalid, o_fwd_rs1/rs2 = 0, counters = 0. o_stall then reads 0 until a slot is valid.
- Stall is decided in ID in the same cycle. Forward select is valid in the following cycle (consumer in EX).
- Stall duration for a load-use: LOAD_AGE-1 cycles (1 at defaults). It releases without an external handshake because slots age every cycle.
- i_flush has priority over stall and issue: no allocation, o_stall = 0 that cycle. Slots already in flight, including the branch, keep shifting.
- Reset asserted mid-stall drops all reservations immediately. The first post-reset issue never stalls.

## Configuration
- SCOREBOARD_PERF_EN defined:
  - o_stall_cnt increments on every cycle with o_stall=1.
  - o_fwd_cnt increments on every issue with either nonzero select.
  - Both are 32-bit and wrap modulo 2^32.
- Undefined: both ports are tied to 0 and no counter flops are synthesised. Port list is unchanged.

## Structure
- Shared package fwd_pkg:
  - slot struct {vld, rd, is_load}.
  - FWD_RF = 0 constant.
  - localparam helpers for ADDR_W and FWD_W.
- One sub-module, sb_lookup: a combinational youngest-match priority search, instantiated twice (rs1, rs2). It returns {hit, age, is_load}.
- Top level holds the slot shift register, stall/select logic, and the optional counters.

## Test plan
- Back-to-back ALU: add x5 then sub x6,x5 → o_stall=0 and next-cycle o_fwd_rs1=1. One cycle later a third instruction reading x5 → o_fwd=2.
- Load-use: lw x7 then add x8,x7,x7 → o_stall=1 for exactly 1 cycle, then o_fwd_rs1=o_fwd_rs2=2. With LOAD_AGE=3, WB_AGE=3 the stall lasts 2 cycles.
- Double writer: addi x9 twice, then a reader of x9 → select=1 (youngest), not 2.
- x0 / no-use: lw x0 followed by a read of x0, and rs2_use=0 with rs2 matching a load → o_stall=0, selects 0.
- Flush during hazard: lw x7, then a dependent instruction in ID with i_flush=1 → o_stall=0, no slot allocated, next-cycle selects 0.
- Reset mid-stall plus counters (SCOREBOARD_PERF_EN): assert i_rst while o_stall=1 → o_stall=0, selects 0, o_stall_cnt=0. After 3 load-use pairs → o_stall_cnt=3.
